cic_decim_mc: RTL
=================

Name: cic_decim_mc

Overview:
- Multi-channel, runtime-programmable CIC decimator. Successor to the single-channel fixed-structure CIC.
- NUM_CHANNELS parallel lanes share one control path.
- An internal rate counter generates the decimation strobe; no external output-strobe input is needed.
- Sits after the mixer/NCO stage in the DSP chain and feeds the downstream FIR/compensation filters.

Parameters:
- DATAIN_WIDTH, 16, per-channel input width (two's complement)
- DATAOUT_WIDTH, DATAIN_WIDTH, per-channel output width
- NUM_CHANNELS, 2, parallel lanes
- N, 5, integrator/comb stage count
- M, 2, differential delay (1 or 2)
- MAXRATE, 64, maximum decimation ratio
- RATE_WIDTH, 16, width of rate_i

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of all state, same effect as reset
- rate_i  in  RATE_WIDTH  decimation ratio R; sampled at each period boundary
- data_i  in  NUM_CHANNELS*DATAIN_WIDTH  packed input samples, channel 0 in LSBs
- valid_i  in  1  input sample strobe, common to all channels
- data_o  out  NUM_CHANNELS*DATAOUT_WIDTH  packed decimated output
- valid_o  out  1  one-cycle output strobe
- rate_err_o  out  1  sticky flag: rate_i was out of range when sampled

Behaviour:
- Reset / clear:
  - Asynchronous assertion of rst_n_i clears integrators, comb delays, comb pipes, sampler, rate counter, active ratio (R_act = 1), fill counter, valid_o, data_o (0) and rate_err_o.
  - clear_i does the same synchronously and has priority over valid_i.
- Accumulator width:
  - ACC_W = DATAIN_WIDTH + N*clog2(M*MAXRATE).
  - Input is sign-extended to ACC_W.
  - All integrator/comb arithmetic is modulo 2^ACC_W; wrap is intentional.
- Integrators:
  - On valid_i, per channel: integ[0] += ext(data_i); integ[k] += integ[k-1] (previous-cycle value).
  - When valid_i is low, state is held.
- Rate counter:
  - cnt counts valid_i strobes from 0 to R_act-1.
  - The strobe where cnt == R_act-1 is the decimation strobe (dec): cnt wraps to 0 and rate_i is sampled into R_act for the next period.
  - Out-of-range rate_i (0, or > MAXRATE) is clamped to 1 or MAXRATE respectively, and rate_err_o is set.
  - A rate change never truncates the current period.
- Comb chain:
  - On dec: sampler <= integ[N-1]. Each comb stage shifts its M-deep delay line and computes pipe[i] = in - delay[i][M-1]. One register per stage per dec; this matches the existing CIC comb timing.
  - Combs hold between dec strobes.
- Output:
  - data_o = top DATAOUT_WIDTH bits of pipe[N-1] (truncation), unless the optional feature below is enabled.
  - Gain is full scale only at R = MAXRATE. At lower R the output is attenuated by (R/MAXRATE)^N; downstream blocks compensate.
- Valid / latency:
  - valid_o pulses for one cycle, the cycle after each dec, once the fill counter has seen N+1 dec strobes since reset/clear. Before that, valid_o stays 0.
  - Sample latency is N+1 output periods through the comb pipe.
- Simultaneous events:
  - clear_i together with valid_i: clear wins and the sample is dropped.
  - dec on the same cycle as a rate_i change: the new value applies to the next period.
- Reset mid-period: all partial accumulation is discarded; the first dec after release occurs after R_act = 1 strobe, then normal behaviour.

Optional Feature:
- CIC_DECIM_MC_ROUND_EN defined: the output is round-half-up.
  - Add 2^(ACC_W-DATAOUT_WIDTH-1) to pipe[N-1] before slicing.
  - Saturate to the max positive code if the add overflows.
  - Adds one register stage: valid_o is one cycle later.
- Undefined: plain truncation, no extra stage.

Decomposition:
- Package cic_decim_pkg holds:
  - function clog2
  - function cic_acc_width(din_w, n, m, maxrate)
  - localparam-style constants for default N/M
  - typedef for rate-error status
- Sub-module cic_decim_lane: one channel's integrators, combs and output slice. Generated NUM_CHANNELS times.
- The top level owns the rate counter, fill counter, valid and error logic.

Test Plan:
1. Impulse, channel 0: R=4, N=5, M=2, one sample 1 then zeros. After fill, outputs (full-width pipe, pre-slice) match the binomial CIC impulse response; channel 1 fed 0 -> stays 0.
2. DC: R=64, input 0x7FFF on both channels. Settled pipe[N-1] = 0x7FFF*(128)^5; data_o = 0x7FFF (trunc) / 0x7FFF (round). valid_o every 64 valid_i strobes.
3. Rate change: R=8, write rate_i=16 mid-period. The current period still completes at 8 strobes; the next valid_o gap is 16.
4. Range errors: rate_i=0 -> R_act=1, rate_err_o=1. rate_i=100 -> R_act=64, rate_err_o stays set until reset/clear.
5. Gated input: valid_i toggled 1-in-3 cycles, R=4. valid_o exactly every 12 clocks; output identical to the ungated run.
6. Reset and clear mid-operation: rst_n_i low mid-period -> all outputs 0 immediately. clear_i with valid_i high -> sample dropped, valid_o low until N+1 new dec strobes.

Source files
------------

// File: rtl/cic_decim_pkg.sv
// Shared helpers and types for the multi-channel CIC decimator.
package cic_decim_pkg;

    localparam int unsigned CIC_DEFAULT_N = 5;
    localparam int unsigned CIC_DEFAULT_M = 2;

    typedef enum logic {
        RATE_OK  = 1'b0,
        RATE_ERR = 1'b1
    } rate_err_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned cic_acc_width(input int unsigned din_w,
                                                  input int unsigned n,
                                                  input int unsigned m,
                                                  input int unsigned maxrate);
        return din_w + n * clog2(m * maxrate);
    endfunction

endpackage

// File: rtl/cic_decim_lane.sv
// One CIC channel: N pipelined integrators, N M-delay combs, output slice.
// CIC_DECIM_MC_ROUND_EN selects a registered round-half-up/saturate output.
module cic_decim_lane #(
    parameter int unsigned DATAIN_WIDTH  = 16,
    parameter int unsigned DATAOUT_WIDTH = 16,
    parameter int unsigned N             = 5,
    parameter int unsigned M             = 2,
    parameter int unsigned ACC_W         = 51
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic                     dec_i,
    input  logic [DATAIN_WIDTH-1:0]  data_i,
    output logic [DATAOUT_WIDTH-1:0] data_o
);

    logic [ACC_W-1:0] integ_q [N];
    logic [ACC_W-1:0] integ_d [N];
    logic [ACC_W-1:0] samp_q, samp_d;
    logic [ACC_W-1:0] dly_q [N][M];
    logic [ACC_W-1:0] dly_d [N][M];
    logic [ACC_W-1:0] pipe_q [N];
    logic [ACC_W-1:0] pipe_d [N];
    logic [ACC_W-1:0] comb_in [N];
    logic [ACC_W-1:0] din_ext;

    assign din_ext = {{(ACC_W-DATAIN_WIDTH){data_i[DATAIN_WIDTH-1]}}, data_i};

    always_comb begin
        integ_d = integ_q;
        samp_d  = samp_q;
        dly_d   = dly_q;
        pipe_d  = pipe_q;
        comb_in[0] = samp_q;
        for (int unsigned i = 1; i < N; i++) comb_in[i] = pipe_q[i-1];

        if (clear_i) begin
            integ_d = '{default: '0};
            samp_d  = '0;
            dly_d   = '{default: '0};
            pipe_d  = '{default: '0};
        end else begin
            // Each integrator adds the previous-cycle value of the stage before it.
            if (valid_i) begin
                integ_d[0] = integ_q[0] + din_ext;
                for (int unsigned k = 1; k < N; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            if (dec_i) begin
                samp_d = integ_q[N-1];
                for (int unsigned i = 0; i < N; i++) begin
                    dly_d[i][0] = comb_in[i];
                    for (int unsigned j = 1; j < M; j++) dly_d[i][j] = dly_q[i][j-1];
                    pipe_d[i] = comb_in[i] - dly_q[i][M-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            integ_q <= '{default: '0};
            samp_q  <= '0;
            dly_q   <= '{default: '0};
            pipe_q  <= '{default: '0};
        end else begin
            integ_q <= integ_d;
            samp_q  <= samp_d;
            dly_q   <= dly_d;
            pipe_q  <= pipe_d;
        end
    end

`ifdef CIC_DECIM_MC_ROUND_EN
    localparam logic [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (ACC_W-DATAOUT_WIDTH-1);

    logic [ACC_W-1:0]         rnd_sum;
    logic [DATAOUT_WIDTH-1:0] rnd_q, rnd_d;

    // Overflow only possible from a non-negative value crossing into the sign bit.
    always_comb begin
        rnd_sum = pipe_q[N-1] + HALF;
        if (clear_i) begin
            rnd_d = '0;
        end else if (!pipe_q[N-1][ACC_W-1] && rnd_sum[ACC_W-1]) begin
            rnd_d = {1'b0, {(DATAOUT_WIDTH-1){1'b1}}};
        end else begin
            rnd_d = rnd_sum[ACC_W-1 -: DATAOUT_WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rnd_q <= '0;
        else          rnd_q <= rnd_d;
    end

    assign data_o = rnd_q;
`else
    assign data_o = pipe_q[N-1][ACC_W-1 -: DATAOUT_WIDTH];
`endif

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel runtime-rate CIC decimator: shared rate/fill/valid/error control.
// CIC_DECIM_MC_ROUND_EN adds a rounding stage and delays valid_o by one cycle.
module cic_decim_mc
    import cic_decim_pkg::*;
#(
    parameter int unsigned DATAIN_WIDTH  = 16,
    parameter int unsigned DATAOUT_WIDTH = DATAIN_WIDTH,
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned N             = CIC_DEFAULT_N,
    parameter int unsigned M             = CIC_DEFAULT_M,
    parameter int unsigned MAXRATE       = 64,
    parameter int unsigned RATE_WIDTH    = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  clear_i,
    input  logic [RATE_WIDTH-1:0]                 rate_i,
    input  logic [NUM_CHANNELS*DATAIN_WIDTH-1:0]  data_i,
    input  logic                                  valid_i,
    output logic [NUM_CHANNELS*DATAOUT_WIDTH-1:0] data_o,
    output logic                                  valid_o,
    output logic                                  rate_err_o
);

    localparam int unsigned ACC_W  = cic_acc_width(DATAIN_WIDTH, N, M, MAXRATE);
    localparam int unsigned CNT_W  = clog2(MAXRATE + 1);
    localparam int unsigned FILL_W = clog2(N + 2);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ract_q, ract_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              valid_q, valid_d;
    rate_err_e         err_q, err_d;
    logic              dec;
    logic [CNT_W-1:0]  rate_clamped;
    logic              rate_bad;

    always_comb begin
        cnt_d        = cnt_q;
        ract_d       = ract_q;
        fill_d       = fill_q;
        err_d        = err_q;
        valid_d      = 1'b0;
        rate_bad     = 1'b0;
        rate_clamped = CNT_W'(rate_i);
        dec          = valid_i && !clear_i && (cnt_q == ract_q - CNT_W'(1));

        if (rate_i == '0) begin
            rate_clamped = CNT_W'(1);
            rate_bad     = 1'b1;
        end else if (rate_i > RATE_WIDTH'(MAXRATE)) begin
            rate_clamped = CNT_W'(MAXRATE);
            rate_bad     = 1'b1;
        end

        if (clear_i) begin
            cnt_d  = '0;
            ract_d = CNT_W'(1);
            fill_d = '0;
            err_d  = RATE_OK;
        end else if (valid_i) begin
            if (dec) begin
                // New ratio is taken only at the period boundary.
                cnt_d  = '0;
                ract_d = rate_clamped;
                if (rate_bad) err_d = RATE_ERR;
                if (fill_q != FILL_W'(N + 1)) fill_d = fill_q + FILL_W'(1);
                valid_d = (fill_q >= FILL_W'(N));
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            ract_q  <= CNT_W'(1);
            fill_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= RATE_OK;
        end else begin
            cnt_q   <= cnt_d;
            ract_q  <= ract_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rate_err_o = (err_q == RATE_ERR);

`ifdef CIC_DECIM_MC_ROUND_EN
    logic valid2_q, valid2_d;

    always_comb valid2_d = clear_i ? 1'b0 : valid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) valid2_q <= 1'b0;
        else          valid2_q <= valid2_d;
    end

    assign valid_o = valid2_q;
`else
    assign valid_o = valid_q;
`endif

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
        cic_decim_lane #(
            .DATAIN_WIDTH (DATAIN_WIDTH),
            .DATAOUT_WIDTH(DATAOUT_WIDTH),
            .N            (N),
            .M            (M),
            .ACC_W        (ACC_W)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .clear_i(clear_i),
            .valid_i(valid_i),
            .dec_i  (dec),
            .data_i (data_i[g*DATAIN_WIDTH +: DATAIN_WIDTH]),
            .data_o (data_o[g*DATAOUT_WIDTH +: DATAOUT_WIDTH])
        );
    end

endmodule
